mult_seq_ctrl: RTL and testbench
================================

Name: mult_seq_ctrl

Overview:
- Moore FSM controller that sequences the shift-and-add multiplier datapath.
- Drives the multiplier right-shift register (load/shift strobes) and the accumulator (clear/add/shift strobes).
- Iterates over N multiplier bits and reports completion with a start/busy/done handshake.
- Sits between the top-level operand interface and the shift-register/adder datapath.

Parameters:
- N, 4, operand width in bits; number of iterations (N >= 2).
- CW, $clog2(N), iteration counter width (derived; not overridden).

Ports:
- clk  input  1  system clock; all state changes on posedge.
- clr  input  1  synchronous active-high reset.
- start  input  1  request a multiply; sampled only in IDLE.
- lsb_b  input  1  current LSB of the multiplier shift register.
- mplr_nz  input  1  1 when the multiplier shift register contents are nonzero.
- sr_en  output  1  shift register enable.
- sr_ld  output  1  shift register mode: 0 = load operand, 1 = shift right (valid when sr_en=1).
- acc_clr  output  1  clear accumulator and latch multiplicand.
- acc_add  output  1  add multiplicand into accumulator.
- acc_shift  output  1  shift multiplicand left by one.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- iter  output  CW  index of the current bit, 0..N-1.

Behaviour:
- Single clock. clr is synchronous: on a posedge with clr=1, state=IDLE, iter=0, and all outputs 0 from the next cycle. clr overrides start.
- All outputs are decoded from registered state only (Moore); there are no combinational paths from inputs to outputs.
- States and outputs:
  - IDLE: all outputs 0.
  - LOAD: sr_en=1, sr_ld=0, acc_clr=1.
  - TEST: no strobes.
  - ADD: acc_add=1.
  - SHIFT: sr_en=1, sr_ld=1, acc_shift=1.
  - DONE: done=1.
  - busy=1 in LOAD, TEST, ADD, SHIFT and DONE.
- Transitions:
  - IDLE -> LOAD if start=1; otherwise stay in IDLE.
  - LOAD -> TEST, with iter cleared to 0.
  - TEST -> ADD if lsb_b=1, else -> SHIFT.
  - ADD -> SHIFT.
  - SHIFT -> DONE if iter==N-1, else -> TEST with iter+1.
  - DONE -> IDLE unconditionally.
- TEST samples lsb_b and mplr_nz after the preceding register update has settled (register updates at the edge ending LOAD/SHIFT).
- Latency: with cycle 1 as the cycle after the start edge, LOAD is cycle 1 and done is high in cycle 2+2N+k, where k = number of 1 bits in the multiplier.
- start while busy (including during DONE) is ignored; it is not queued.
- start held high continuously: a new operation begins on the IDLE cycle that follows DONE.
- iter never exceeds N-1; no wrap occurs within an operation.
- Unknown or illegal state encoding -> IDLE on the next edge.

Optional Feature:
- Macro: MULT_EARLY_EXIT_EN.
- Defined: in TEST, mplr_nz=0 -> DONE directly, skipping the remaining iterations. iter holds its value. The accumulator result remains correct because the remaining bits are zero.
- Undefined: mplr_nz is ignored and the controller always runs N iterations (fixed latency for a given k).

Decomposition:
- Shared package mult_pkg:
  - state enum (IDLE, LOAD, TEST, ADD, SHIFT, DONE), 3-bit encoding;
  - SR_LOAD=0, SR_SHIFT=1 mode constants;
  - default N.
- One sub-module: mult_bit_cnt, a CW-bit iteration counter with sync clear, increment and terminal-count (==N-1) output.
- The FSM and output decode stay in mult_seq_ctrl.

Test Plan:
- Reset: clr=1 mid-ADD at N=4 -> next cycle state IDLE, busy=0, done=0, iter=0, all strobes 0; start held with clr=1 -> remains IDLE.
- Full run, N=4, multiplier 4'b1011: start pulse -> LOAD in cycle 1, acc_add asserted 3 times, sr_ld=1 shifts 4 times, done=1 in cycle 13 for exactly one cycle, then IDLE.
- Zero multiplier, N=4, macro undefined: lsb_b=0, mplr_nz=0 throughout -> no acc_add, done in cycle 10.
- Early exit, macro defined, N=4, multiplier 4'b0001: LOAD, TEST, ADD, SHIFT, TEST (mplr_nz=0) -> done in cycle 6, iter=1.
- start asserted during SHIFT and during DONE -> ignored; start held high continuously -> back-to-back operations with one IDLE cycle between done and the next LOAD.
- N=8 parameter sweep, multiplier 8'hFF -> 8 adds, done in cycle 26, iter reaches 7 and never 8.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier controller:
// state encoding, shift-register mode constants and the default operand width.
package mult_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        TEST  = 3'd2,
        ADD   = 3'd3,
        SHIFT = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic SR_LOAD  = 1'b0;
    localparam logic SR_SHIFT = 1'b1;

    localparam int N_DEFAULT = 4;

endpackage

// File: rtl/mult_bit_cnt.sv
// Iteration counter for the multiplier controller: synchronous clear,
// increment, and a terminal-count flag raised on the last bit index (N-1).
module mult_bit_cnt
    import mult_pkg::*;
#(
    parameter int N = N_DEFAULT,
    localparam int CW = $clog2(N)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          tc
);

    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    // Increment saturates at the terminal count so the index never wraps.
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (inc && !tc) begin
            cnt <= cnt + ONE;
        end
    end

    assign tc = (cnt == LAST);

endmodule

// File: rtl/mult_seq_ctrl.sv
// Moore controller sequencing the shift-and-add multiplier datapath.
// Define MULT_EARLY_EXIT_EN to finish as soon as the multiplier register is zero.
module mult_seq_ctrl
    import mult_pkg::*;
#(
    parameter int N = N_DEFAULT,
    localparam int CW = $clog2(N)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          start,
    input  logic          lsb_b,
    input  logic          mplr_nz,
    output logic          sr_en,
    output logic          sr_ld,
    output logic          acc_clr,
    output logic          acc_add,
    output logic          acc_shift,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] iter
);

    state_t state;
    state_t next_state;
    logic   cnt_clr;
    logic   cnt_inc;
    logic   last_bit;

`ifndef MULT_EARLY_EXIT_EN
    // Without early exit the nonzero flag plays no part in sequencing.
    logic unused_mplr_nz;
    assign unused_mplr_nz = mplr_nz;
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The index restarts when an operation is loaded and advances on each
    // shift that is not the final one.
    assign cnt_clr = clr || (state == LOAD);
    assign cnt_inc = (state == SHIFT);

    mult_bit_cnt #(
        .N (N)
    ) u_bit_cnt (
        .clk (clk),
        .clr (cnt_clr),
        .inc (cnt_inc),
        .cnt (iter),
        .tc  (last_bit)
    );

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  next_state = start ? LOAD : IDLE;
            LOAD:  next_state = TEST;
            TEST: begin
`ifdef MULT_EARLY_EXIT_EN
                if (!mplr_nz) begin
                    next_state = DONE;
                end else begin
                    next_state = lsb_b ? ADD : SHIFT;
                end
`else
                next_state = lsb_b ? ADD : SHIFT;
`endif
            end
            ADD:   next_state = SHIFT;
            SHIFT: next_state = last_bit ? DONE : TEST;
            DONE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        sr_en     = 1'b0;
        sr_ld     = SR_LOAD;
        acc_clr   = 1'b0;
        acc_add   = 1'b0;
        acc_shift = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            LOAD: begin
                sr_en   = 1'b1;
                sr_ld   = SR_LOAD;
                acc_clr = 1'b1;
                busy    = 1'b1;
            end
            TEST: begin
                busy = 1'b1;
            end
            ADD: begin
                acc_add = 1'b1;
                busy    = 1'b1;
            end
            SHIFT: begin
                sr_en     = 1'b1;
                sr_ld     = SR_SHIFT;
                acc_shift = 1'b1;
                busy      = 1'b1;
            end
            DONE: begin
                done = 1'b1;
                busy = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl: drives an N=4 and an N=8 controller, each with a
// behavioural shift register / accumulator, and scores products at done.
module tb_mult_seq_ctrl;

    logic clk = 1'b0;
    logic clr = 1'b1;
    logic start4 = 1'b0;
    logic start8 = 1'b0;
    logic [7:0] a_op = '0;
    logic [7:0] b_op = '0;

    // clock / reset
    always #5 clk = ~clk;

    logic       sr_en4, sr_ld4, acc_clr4, acc_add4, acc_shift4, busy4, done4;
    logic [1:0] iter4;
    logic       sr_en8, sr_ld8, acc_clr8, acc_add8, acc_shift8, busy8, done8;
    logic [2:0] iter8;

    logic [7:0]  sr4 = '0, sr8 = '0;
    logic [15:0] acc4 = '0, acc8 = '0, mc4 = '0, mc8 = '0;
    logic        lsb4, nz4, lsb8, nz8;

    assign lsb4 = sr4[0];
    assign nz4  = |sr4;
    assign lsb8 = sr8[0];
    assign nz8  = |sr8;

    mult_seq_ctrl #(.N(4)) dut4 (
        .clk(clk), .clr(clr), .start(start4), .lsb_b(lsb4), .mplr_nz(nz4),
        .sr_en(sr_en4), .sr_ld(sr_ld4), .acc_clr(acc_clr4), .acc_add(acc_add4),
        .acc_shift(acc_shift4), .busy(busy4), .done(done4), .iter(iter4)
    );

    mult_seq_ctrl #(.N(8)) dut8 (
        .clk(clk), .clr(clr), .start(start8), .lsb_b(lsb8), .mplr_nz(nz8),
        .sr_en(sr_en8), .sr_ld(sr_ld8), .acc_clr(acc_clr8), .acc_add(acc_add8),
        .acc_shift(acc_shift8), .busy(busy8), .done(done8), .iter(iter8)
    );

    // datapath models driven by the controller strobes
    always @(posedge clk) begin
        if (sr_en4) sr4 <= sr_ld4 ? (sr4 >> 1) : (b_op & 8'h0F);
        if (acc_clr4) begin
            acc4 <= '0;
            mc4  <= {8'h00, a_op};
        end else begin
            if (acc_add4)   acc4 <= acc4 + mc4;
            if (acc_shift4) mc4  <= mc4 << 1;
        end
    end

    always @(posedge clk) begin
        if (sr_en8) sr8 <= sr_ld8 ? (sr8 >> 1) : b_op;
        if (acc_clr8) begin
            acc8 <= '0;
            mc8  <= {8'h00, a_op};
        end else begin
            if (acc_add8)   acc8 <= acc8 + mc8;
            if (acc_shift8) mc8  <= mc8 << 1;
        end
    end

    // monitor mux: sel=0 watches dut4, sel=1 watches dut8
    logic       sel = 1'b0;
    logic       m_done, m_busy, m_add, m_sren, m_srld, m_clr;
    logic [3:0] m_iter;
    assign m_done = sel ? done8    : done4;
    assign m_busy = sel ? busy8    : busy4;
    assign m_add  = sel ? acc_add8 : acc_add4;
    assign m_sren = sel ? sr_en8   : sr_en4;
    assign m_srld = sel ? sr_ld8   : sr_ld4;
    assign m_clr  = sel ? acc_clr8 : acc_clr4;
    assign m_iter = sel ? {1'b0, iter8} : {2'b00, iter4};

    int tests = 0;
    int fails = 0;
    logic [15:0] exp_q4[$];
    logic [15:0] exp_q8[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // scoreboard: products popped when each controller signals done
    always @(negedge clk) begin
        if (done4) begin
            if (exp_q4.size() == 0) check("sb4_unexpected_done", 1, 0);
            else check("sb4_product", acc4, exp_q4.pop_front());
        end
        if (done8) begin
            if (exp_q8.size() == 0) check("sb8_unexpected_done", 1, 0);
            else check("sb8_product", acc8, exp_q8.pop_front());
        end
    end

    // reference sequencing: cycle of done, adds, shifts and final index
    function automatic void exp_model(input logic [7:0] b, input int n, output int dcyc,
                                      output int adds, output int shifts, output int it);
        logic [7:0] m;
        m = b;
        dcyc = 1;
        adds = 0;
        shifts = 0;
        it = n - 1;
        for (int i = 0; i < n; i++) begin
            dcyc++;
`ifdef MULT_EARLY_EXIT_EN
            if (m == 0) begin
                it = i;
                dcyc++;
                return;
            end
`endif
            if (m[0]) begin
                dcyc++;
                adds++;
            end
            dcyc++;
            shifts++;
            m = m >> 1;
        end
        dcyc++;
    endfunction

    task automatic set_start(input int s, input logic v);
        if (s == 0) start4 = v;
        else start8 = v;
    endtask

    // driver: one operation from start pulse to the IDLE cycle after done
    task automatic run_op(input int s, input logic [7:0] a, input logic [7:0] b_raw, input bit poke);
        logic [7:0] b;
        int cyc, done_cyc, adds, shifts, maxiter, it_done;
        int e_dcyc, e_adds, e_shifts, e_it;
        b = (s == 0) ? (b_raw & 8'h0F) : b_raw;
        exp_model(b, (s == 0) ? 4 : 8, e_dcyc, e_adds, e_shifts, e_it);
        sel = (s != 0);
        @(negedge clk);
        a_op = a;
        b_op = b;
        set_start(s, 1'b1);
        if (s == 0) exp_q4.push_back(16'(a) * 16'(b));
        else exp_q8.push_back(16'(a) * 16'(b));
        cyc = 0; done_cyc = 0; adds = 0; shifts = 0; maxiter = 0; it_done = 0;
        while (done_cyc == 0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            set_start(s, 1'b0);
            if (cyc == 1) check("load_in_cycle1", {m_sren, m_srld, m_clr, m_busy}, 4'b1011);
            if (m_add) adds++;
            if (m_sren && m_srld) begin
                shifts++;
                if (poke) set_start(s, 1'b1);
            end
            if (int'(m_iter) > maxiter) maxiter = int'(m_iter);
            if (m_done) begin
                done_cyc = cyc;
                it_done = int'(m_iter);
                if (poke) set_start(s, 1'b1);
            end
        end
        check("done_seen", (done_cyc != 0), 1);
        check("done_cycle", done_cyc, e_dcyc);
        check("add_count", adds, e_adds);
        check("shift_count", shifts, e_shifts);
        check("iter_max", maxiter, e_it);
        check("iter_at_done", it_done, e_it);
        @(negedge clk);
        set_start(s, 1'b0);
        check("idle_after_done", {m_busy, m_done}, 2'b00);
        if (poke) begin
            @(negedge clk);
            check("start_in_done_ignored", {m_busy, m_sren}, 2'b00);
        end
    endtask

    int  n_wait;
    bit  found;

    initial begin
        // reset state of both controllers
        repeat (2) @(negedge clk);
        check("reset_outs4", {sr_en4, sr_ld4, acc_clr4, acc_add4, acc_shift4, busy4, done4}, 0);
        check("reset_iter4", iter4, 0);
        check("reset_outs8", {sr_en8, sr_ld8, acc_clr8, acc_add8, acc_shift8, busy8, done8}, 0);
        check("reset_iter8", iter8, 0);
        clr = 1'b0;

        // N=4 directed runs: 1011, zero multiplier, single low bit
        run_op(0, 8'd13, 8'b1011, 1'b0);
        run_op(0, 8'd9, 8'b0000, 1'b0);
        run_op(0, 8'd7, 8'b0001, 1'b0);
        // start pulses during SHIFT and DONE must be ignored
        run_op(0, 8'd200, 8'b0110, 1'b1);
        for (int i = 0; i < 3; i++) begin
            run_op(0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 15)), 1'b0);
        end

        // start held high: one IDLE cycle between done and the next LOAD
        sel = 1'b0;
        @(negedge clk);
        a_op = 8'd5;
        b_op = 8'b0101;
        start4 = 1'b1;
        exp_q4.push_back(16'd25);
        exp_q4.push_back(16'd25);
        n_wait = 0;
        found = 1'b0;
        while (!found && n_wait < 100) begin
            @(negedge clk);
            n_wait++;
            if (m_done) found = 1'b1;
        end
        check("hold_first_done", found, 1);
        @(negedge clk);
        check("hold_idle_gap", {m_busy, m_done}, 2'b00);
        @(negedge clk);
        check("hold_second_load", {m_sren, m_srld, m_clr, m_busy}, 4'b1011);
        start4 = 1'b0;
        n_wait = 0;
        found = 1'b0;
        while (!found && n_wait < 100) begin
            @(negedge clk);
            n_wait++;
            if (m_done) found = 1'b1;
        end
        check("hold_second_done", found, 1);
        @(negedge clk);

        // clr asserted while in ADD
        @(negedge clk);
        a_op = 8'd3;
        b_op = 8'b1011;
        start4 = 1'b1;
        exp_q4.push_back(16'd33);
        n_wait = 0;
        found = 1'b0;
        while (!found && n_wait < 20) begin
            @(negedge clk);
            n_wait++;
            start4 = 1'b0;
            if (m_add) found = 1'b1;
        end
        check("reached_add", found, 1);
        clr = 1'b1;
        @(negedge clk);
        check("clr_mid_add_outs", {sr_en4, sr_ld4, acc_clr4, acc_add4, acc_shift4, busy4, done4}, 0);
        check("clr_mid_add_iter", iter4, 0);
        start4 = 1'b1;
        repeat (2) @(negedge clk);
        check("clr_overrides_start", {busy4, sr_en4}, 2'b00);
        clr = 1'b0;
        start4 = 1'b0;
        exp_q4.delete();
        @(negedge clk);
        check("idle_after_clr", busy4, 0);

        // N=8 sweep
        run_op(1, 8'hA5, 8'hFF, 1'b0);
        run_op(1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
        run_op(1, 8'hFF, 8'h80, 1'b1);

        repeat (2) @(negedge clk);
        check("sb4_drained", exp_q4.size(), 0);
        check("sb8_drained", exp_q8.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
